// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: 3-to-7 sequential decoder.
// Codes arrive through a valid/ready handshake into a 2-entry FIFO.
// Each popped code is expanded to a one-hot word and held for HOLD_CYCLES
// cycles, then followed by one idle GAP cycle before the next pop.
module onehot_decoder_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    output logic [6:0]       out_x,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] code_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [2:0]       mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [7:0]       hold_q;
    logic [6:0]       out_x_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] code_cnt_q;

    logic             push;
    logic             pop;
    logic [2:0]       head_code;
    logic [6:0]       dec_x;

    // Handshake and status: ready depends only on the current FIFO count.
    always_comb begin
        in_ready  = rst_n && (count_q < 2'd2);
        push      = in_valid && in_ready;
        pop       = (state_q == IDLE) && (count_q != 2'd0);
        busy      = rst_n && ((state_q != IDLE) || (count_q != 2'd0));
        head_code = mem_q[rd_ptr_q];
    end

    // Expand the FIFO head into its one-hot word; code 0 means no bit set.
    always_comb begin
        dec_x = '0;
        if (head_code != 3'd0) begin
            dec_x = 7'd1 << (head_code - 3'd1);
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Output sequencer: load on pop, hold for HOLD_CYCLES, then one gap cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            out_x_q     <= '0;
            out_valid_q <= 1'b0;
            code_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        out_x_q     <= dec_x;
                        out_valid_q <= 1'b1;
                        hold_q      <= HOLD_INIT;
                        if (code_cnt_q != '1) begin
                            code_cnt_q <= code_cnt_q + 1'b1;
                        end
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (hold_q == 8'd0) begin
                        out_x_q     <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= GAP;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_x     = out_x_q;
    assign out_valid = out_valid_q;
    assign code_cnt  = code_cnt_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Testbench for onehot_decoder_seq: two instances (8-bit and 3-bit counter)
// share stimulus and are checked every cycle against a timeline model.
module tb_onehot_decoder_seq;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;

    logic       in_ready,   busy,   out_valid;
    logic [6:0] out_x;
    logic [7:0] code_cnt;
    logic       in_ready_s, busy_s, out_valid_s;
    logic [6:0] out_x_s;
    logic [2:0] code_cnt_s;

    onehot_decoder_seq #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_x(out_x), .out_valid(out_valid),
        .busy(busy), .code_cnt(code_cnt)
    );

    onehot_decoder_seq #(.HOLD_CYCLES(H), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_code(in_code), .out_x(out_x_s), .out_valid(out_valid_s),
        .busy(busy_s), .code_cnt(code_cnt_s)
    );

    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // Timeline model: a popped code owns the output for edges
    // [win_start, win_start+H) and the next pop may happen at win_start+H+2.
    int         edge_n    = 0;
    int         q[$];
    int         next_pop  = 0;
    int         win_start = -100;
    int         popped    = 0;
    logic [6:0] cur_x     = '0;
    bit         accepted  = 0;

    logic [30:0] exp_vec;
    logic [30:0] act_vec;
    assign act_vec = {in_ready, busy, out_valid, out_x, code_cnt,
                      in_ready_s, busy_s, out_valid_s, out_x_s, code_cnt_s};

    task automatic apply(input bit v, input logic [2:0] c, input bit r);
        bit         rdy, ev, er, eb;
        logic [6:0] ex;
        int         c8, c3;
        @(negedge clk);
        in_valid = v;
        in_code  = c;
        rst_n    = r;
        @(posedge clk);
        edge_n++;
        accepted = 0;
        if (!r) begin
            q.delete();
            next_pop  = edge_n + 1;
            win_start = -100;
            popped    = 0;
        end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && edge_n >= next_pop) begin
                cur_x     = (q[0] == 0) ? 7'd0 : 7'(1 << (q[0] - 1));
                void'(q.pop_front());
                win_start = edge_n;
                next_pop  = edge_n + H + 2;
                popped++;
            end
            if (v && rdy) begin
                q.push_back(int'(c));
                accepted = 1;
            end
        end
        #1;
        ev = (edge_n >= win_start) && (edge_n < win_start + H);
        ex = ev ? cur_x : 7'd0;
        c8 = (popped > 255) ? 255 : popped;
        c3 = (popped > 7) ? 7 : popped;
        er = r && (q.size() < 2);
        eb = r && ((edge_n < next_pop - 1) || (q.size() > 0));
        exp_vec = {er, eb, ev, ex, 8'(c8), er, eb, ev, ex, 3'(c3)};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply((i == 1), 3'($urandom), 1'b0);
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL reset[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
        apply(1'b0, 3'd0, 1'b1);
        vecs++;
        if (act_vec !== exp_vec) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_single();
        int win = 0;
        apply(1'b0, 3'd0, 1'b0);
        apply(1'b1, 3'd5, 1'b1);
        for (int i = 0; i < 12; i++) begin
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL single[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
            if (out_valid === 1'b1 && out_x === 7'b0010000) win++;
            apply(1'b0, 3'($urandom), 1'b1);
        end
        vecs++;
        if (win != 4) begin
            fails++;
            $display("FAIL single_window_len: got %0d expected 4", win);
        end
        vecs++;
        if (code_cnt !== 8'd1) begin
            fails++;
            $display("FAIL single_cnt: got %0d expected 1", code_cnt);
        end
    endtask

    task automatic test_sweep();
        apply(1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < 20; t++) begin
                apply(1'b1, 3'(k), 1'b1);
                vecs++;
                if (act_vec !== exp_vec) begin
                    fails++;
                    $display("FAIL sweep[%0d.%0d]: got %h expected %h", k, t, act_vec, exp_vec);
                end
                if (accepted) break;
            end
        end
        for (int i = 0; i < 24; i++) begin
            apply(1'b0, 3'($urandom), 1'b1);
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL sweep_drain[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
        vecs++;
        if (code_cnt !== 8'd8) begin
            fails++;
            $display("FAIL sweep_cnt: got %0d expected 8", code_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] seen[$];
        logic [6:0] want [4];
        bit         prev_v = 0;
        int         idx    = 0;
        want = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000};
        apply(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            apply((idx < 4), 3'(idx + 1), 1'b1);
            if (accepted) idx++;
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL backpressure[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
            if (out_valid === 1'b1 && !prev_v) seen.push_back(out_x);
            prev_v = (out_valid === 1'b1);
        end
        vecs++;
        if (seen.size() != 4) begin
            fails++;
            $display("FAIL backpressure_count: got %0d expected 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (seen[i] !== want[i]) begin
                    fails++;
                    $display("FAIL backpressure_order[%0d]: got %b expected %b", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(1'b0, 3'd0, 1'b0);
        apply(1'b1, 3'd7, 1'b1);
        apply(1'b0, 3'd0, 1'b1);
        apply(1'b0, 3'd0, 1'b1);
        vecs++;
        if (act_vec !== exp_vec) begin
            fails++;
            $display("FAIL mid_reset_drive2: got %h expected %h", act_vec, exp_vec);
        end
        apply(1'b0, 3'd0, 1'b0);
        vecs++;
        if ({out_valid, out_x, code_cnt, busy} !== 17'd0) begin
            fails++;
            $display("FAIL mid_reset_clear: got v=%b x=%b cnt=%0d busy=%b expected all 0",
                     out_valid, out_x, code_cnt, busy);
        end
        apply(1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 3'($urandom), 1'b1);
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL mid_reset_after[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_push_pop();
        apply(1'b0, 3'd0, 1'b0);
        apply(1'b1, 3'd3, 1'b1);
        apply(1'b1, 3'd6, 1'b1);
        for (int i = 0; i < 16; i++) begin
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL push_pop[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
            apply(1'b0, 3'($urandom), 1'b1);
        end
    endtask

    task automatic test_saturation();
        apply(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            apply(1'b1, 3'($urandom), 1'b1);
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
        vecs++;
        if (code_cnt_s !== 3'd7 || code_cnt < 8'd9) begin
            fails++;
            $display("FAIL saturation_hold: got cnt3=%0d cnt8=%0d expected 7 and >=9",
                     code_cnt_s, code_cnt);
        end
    endtask

    task automatic test_random();
        apply(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom), 3'($urandom), ($urandom_range(0, 49) != 0));
            vecs++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_mid_reset();
        test_push_pop();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
